// File: rtl/multi_digit_hex_display.sv
// multi_digit_hex_display
//   N-digit multiplexed 7-segment hex display driver with an on-board up/down
//   counter. Three raw push-buttons are synchronised, debounced and
//   edge-detected. The counter value is time-multiplexed across NUM_DIGITS
//   common-ground digits at a rate chosen by a tap on a free-running prescaler.
//
// Ports
//   i_clk        system clock
//   i_rst_n      asynchronous active-low reset
//   i_btn_inc    raw button, count up
//   i_btn_dec    raw button, count down
//   i_btn_speed  raw button, step the scan-rate tap
//   i_blank_en   1 = blank leading zeros (digit 0 always shown)
//   o_segments   {a,b,c,d,e,f,g}, polarity set by SEG_ACTIVE_LOW
//   o_grounds    one-hot digit enable, active high
//   o_value      current counter value
//   o_scan_sel   current prescaler tap index
module multi_digit_hex_display #(
  parameter int                      NUM_DIGITS     = 4,
  parameter logic [4*NUM_DIGITS-1:0] INIT_VALUE     = '0,
  parameter int                      DB_CYCLES      = 500000,
  parameter int                      PRESC_W        = 26,
  parameter int                      SCAN_SEL_INIT  = 10,
  parameter int                      SCAN_STEP      = 3,
  parameter bit                      SEG_ACTIVE_LOW = 1'b1,
  localparam int                     VW             = 4*NUM_DIGITS,
  localparam int                     SW             = (PRESC_W > 1) ? $clog2(PRESC_W) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_btn_inc,
  input  logic                  i_btn_dec,
  input  logic                  i_btn_speed,
  input  logic                  i_blank_en,
  output logic [6:0]            o_segments,
  output logic [NUM_DIGITS-1:0] o_grounds,
  output logic [VW-1:0]         o_value,
  output logic [SW-1:0]         o_scan_sel
);

  localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int NB = 3;

  // ---------------------------------------------------------------------------
  // Button lanes: 0 = inc, 1 = dec, 2 = speed
  // ---------------------------------------------------------------------------
  logic [NB-1:0] w_btn_raw;
  logic [NB-1:0] w_pulse;

  assign w_btn_raw = {i_btn_speed, i_btn_dec, i_btn_inc};

  for (genvar b = 0; b < NB; b++) begin : g_db
    logic [1:0]    r_sync;
    logic          r_stable;
    logic          r_stable_d;
    logic [CW-1:0] r_cnt;

    // r_cnt counts consecutive synchronised samples that disagree with the
    // accepted level; the level flips on the DB_CYCLES-th such sample.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_sync     <= '0;
        r_stable   <= 1'b0;
        r_stable_d <= 1'b0;
        r_cnt      <= '0;
      end else begin
        r_sync     <= {r_sync[0], w_btn_raw[b]};
        r_stable_d <= r_stable;
        if (r_sync[1] == r_stable) begin
          r_cnt <= '0;
        end else if (r_cnt == CW'(DB_CYCLES - 1)) begin
          r_stable <= r_sync[1];
          r_cnt    <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end

    assign w_pulse[b] = r_stable & ~r_stable_d;
  end

  logic w_inc, w_dec, w_speed;
  assign w_inc   = w_pulse[0];
  assign w_dec   = w_pulse[1];
  assign w_speed = w_pulse[2];

  // ---------------------------------------------------------------------------
  // Up/down counter, wraps naturally at the register width
  // ---------------------------------------------------------------------------
  logic [VW-1:0] r_value;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_value <= INIT_VALUE;
    end else if (w_inc && !w_dec) begin
      r_value <= r_value + 1'b1;
    end else if (w_dec && !w_inc) begin
      r_value <= r_value - 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Scan-rate tap selection
  // ---------------------------------------------------------------------------
  logic [SW-1:0] r_scan_sel;
  logic          r_sel_chg;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_scan_sel <= SW'(SCAN_SEL_INIT);
      r_sel_chg  <= 1'b0;
    end else begin
      r_sel_chg <= w_speed;
      if (w_speed) begin
        if (int'(r_scan_sel) + SCAN_STEP > PRESC_W - 1)
          r_scan_sel <= '0;
        else
          r_scan_sel <= r_scan_sel + SW'(SCAN_STEP);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Prescaler and scan tick
  // ---------------------------------------------------------------------------
  logic [PRESC_W-1:0] r_presc;
  logic               r_tap_prev;
  logic               w_tap;
  logic               w_tick;

  assign w_tap = r_presc[r_scan_sel];
  // r_tap_prev still holds the old tap in the cycle after a tap change, so a
  // rising edge seen then is an artefact of the switch and is suppressed.
  assign w_tick = w_tap & ~r_tap_prev & ~r_sel_chg;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_presc    <= '0;
      r_tap_prev <= 1'b0;
    end else begin
      r_presc    <= r_presc + 1'b1;
      r_tap_prev <= w_tap;
    end
  end

  // ---------------------------------------------------------------------------
  // Digit index and one-hot ground rotation
  // ---------------------------------------------------------------------------
  logic [DW-1:0]         r_digit;
  logic [NUM_DIGITS-1:0] r_grounds;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_digit   <= '0;
      r_grounds <= NUM_DIGITS'(1);
    end else if (w_tick) begin
      r_digit   <= (r_digit == DW'(NUM_DIGITS - 1)) ? '0 : r_digit + 1'b1;
      r_grounds <= (r_grounds << 1) | (r_grounds >> (NUM_DIGITS - 1));
    end
  end

  // ---------------------------------------------------------------------------
  // Segment decode and leading-zero blanking
  // ---------------------------------------------------------------------------
  function automatic logic [6:0] f_seg7(input logic [3:0] n);
    logic [6:0] c;
    case (n)
      4'h0:    c = 7'b0000001;
      4'h1:    c = 7'b1001111;
      4'h2:    c = 7'b0010010;
      4'h3:    c = 7'b0000110;
      4'h4:    c = 7'b1001100;
      4'h5:    c = 7'b0100100;
      4'h6:    c = 7'b0100000;
      4'h7:    c = 7'b0001111;
      4'h8:    c = 7'b0000000;
      4'h9:    c = 7'b0000100;
      4'hA:    c = 7'b0001000;
      4'hB:    c = 7'b1100000;
      4'hC:    c = 7'b0110001;
      4'hD:    c = 7'b1000010;
      4'hE:    c = 7'b0110000;
      default: c = 7'b0111000;
    endcase
    return c;
  endfunction

  logic [NUM_DIGITS-1:0][3:0] w_nib;
  logic [NUM_DIGITS-1:0]      w_hi_zero;
  logic [3:0]                 w_nib_sel;
  logic                       w_blank;
  logic [6:0]                 w_seg_al;

  assign w_nib = r_value;

  // w_hi_zero[d]: nibble d and every nibble above it are zero
  for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_hz
    assign w_hi_zero[d] = (r_value[VW-1:4*d] == '0);
  end

  assign w_nib_sel = w_nib[r_digit];
  assign w_blank   = i_blank_en && (r_digit != '0) && w_hi_zero[r_digit];
  assign w_seg_al  = w_blank ? 7'b1111111 : f_seg7(w_nib_sel);

  assign o_segments = SEG_ACTIVE_LOW ? w_seg_al : ~w_seg_al;
  assign o_grounds  = r_grounds;
  assign o_value    = r_value;
  assign o_scan_sel = r_scan_sel;

endmodule

// File: tb/tb_multi_digit_hex_display.sv
module tb_multi_digit_hex_display;
  localparam int ND  = 4;
  localparam int DB  = 4;
  localparam int PW  = 8;
  localparam int SSI = 2;
  localparam int SST = 3;

  logic clk = 1'b0, rst_n = 1'b0;
  logic btn_inc = 1'b0, btn_dec = 1'b0, btn_speed = 1'b0, blank_en = 1'b0;
  logic [6:0]  seg0, seg1;
  logic [3:0]  gnd0, gnd1;
  logic [15:0] val0, val1;
  logic [2:0]  sel0, sel1;

  int n_chk = 0, n_fail = 0;
  int m_val, m_sel;

  // active-low codes, digits 0..F
  logic [6:0] codes [0:15] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  multi_digit_hex_display #(
    .NUM_DIGITS(ND), .INIT_VALUE(16'h0000), .DB_CYCLES(DB), .PRESC_W(PW),
    .SCAN_SEL_INIT(SSI), .SCAN_STEP(SST), .SEG_ACTIVE_LOW(1'b1)
  ) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_btn_inc(btn_inc), .i_btn_dec(btn_dec),
    .i_btn_speed(btn_speed), .i_blank_en(blank_en), .o_segments(seg0),
    .o_grounds(gnd0), .o_value(val0), .o_scan_sel(sel0));

  multi_digit_hex_display #(
    .NUM_DIGITS(ND), .INIT_VALUE(16'h0008), .DB_CYCLES(DB), .PRESC_W(PW),
    .SCAN_SEL_INIT(SSI), .SCAN_STEP(SST), .SEG_ACTIVE_LOW(1'b0)
  ) u_dut_hi (
    .i_clk(clk), .i_rst_n(rst_n), .i_btn_inc(1'b0), .i_btn_dec(1'b0),
    .i_btn_speed(1'b0), .i_blank_en(1'b1), .o_segments(seg1),
    .o_grounds(gnd1), .o_value(val1), .o_scan_sel(sel1));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference segment pattern: lit/unlit from the hex table, leading-zero rule
  function automatic logic [6:0] exp_seg(input int v, input int d, input bit blank, input bit al);
    logic [6:0] c;
    if (blank && d != 0 && (v >> (4*d)) == 0) c = 7'b1111111;
    else                                      c = codes[(v >> (4*d)) & 15];
    return al ? c : ~c;
  endfunction

  function automatic int idx_of(input logic [3:0] g);
    for (int i = 0; i < ND; i++) if (g[i]) return i;
    return 0;
  endfunction

  // A press accepted by the debouncer needs at least DB cycles of high level
  task automatic press(input bit i, input bit d, input bit s, input int hold);
    btn_inc = i; btn_dec = d; btn_speed = s;
    cyc(hold);
    btn_inc = 0; btn_dec = 0; btn_speed = 0;
    cyc(12);
    if (hold >= DB) begin
      if (i && !d) m_val = (m_val + 1) % 65536;
      if (d && !i) m_val = (m_val + 65535) % 65536;
      if (s) m_sel = (m_sel + SST > PW - 1) ? 0 : m_sel + SST;
    end
  endtask

  task automatic wait_digit(input bit hi, input int d);
    int n;
    n = 0;
    while (((hi ? gnd1 : gnd0) != 4'(1 << d)) && n < 2500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2500) chk("digit_timeout", 32'(hi ? gnd1 : gnd0), 32'(1 << d));
  endtask

  initial begin
    logic [3:0] prev_g;
    int nchg, last_t, old;

    // ---- power-on reset
    m_val = 0; m_sel = SSI;
    cyc(3);
    chk("rst_value", val0, 0);
    chk("rst_grounds", gnd0, 4'b0001);
    chk("rst_scan_sel", sel0, SSI);
    chk("rst_value_hi", val1, 16'h0008);
    rst_n = 1'b1;

    // ---- scan rotation: one step every 2^(scan_sel+1) clocks
    prev_g = gnd0; nchg = 0; last_t = 0;
    for (int t = 1; t <= 100 && nchg < 5; t++) begin
      @(negedge clk);
      chk("onehot", $countones(gnd0), 1);
      if (gnd0 != prev_g) begin
        nchg++;
        chk("scan_rot", gnd0, {prev_g[2:0], prev_g[3]});
        if (nchg > 1) chk("scan_period", t - last_t, 8);
        last_t = t;
        prev_g = gnd0;
      end
    end
    chk("scan_changes", nchg, 5);

    // ---- bouncing: every high run shorter than DB, no change
    foreach (codes[k]) begin
      if (k < 5) begin
        btn_inc = 1'b1; cyc((k % 3) + 1);
        btn_inc = 1'b0; cyc(1);
      end
    end
    cyc(12);
    chk("bounce_nochg", val0, m_val);

    // ---- latency: value steps 7 cycles after the button rises
    old = m_val;
    btn_inc = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk($sformatf("lat_k%0d", k), val0, (k >= 7) ? (old + 1) % 65536 : old);
    end
    cyc(12);
    btn_inc = 1'b0;
    cyc(12);
    m_val = (old + 1) % 65536;
    chk("hold_once", val0, m_val);

    // ---- wrap both ways and simultaneous inc+dec
    press(0, 1, 0, 6); chk("dec_to0", val0, m_val);
    press(0, 1, 0, 6); chk("wrap_down", val0, m_val);
    chk("wrap_down_ffff", val0, 16'hFFFF);
    press(1, 0, 0, 6); chk("wrap_up", val0, 16'h0000);
    press(0, 1, 0, 6); chk("wrap_down2", val0, 16'hFFFF);
    press(1, 1, 0, 6); chk("inc_dec_same", val0, 16'hFFFF);

    // ---- speed steps: 2 -> 5 -> 0 -> 3
    press(0, 0, 1, 6); chk("speed1", sel0, 5);
    press(0, 0, 1, 6); chk("speed2", sel0, 0);
    press(0, 0, 1, 6); chk("speed3", sel0, 3);
    m_sel = 3;

    // ---- randomized episodes against the model
    for (int e = 0; e < 30; e++) begin
      int kind, hold;
      kind = $urandom_range(0, 3);
      hold = $urandom_range(1, 12);
      blank_en = 1'($urandom_range(0, 1));
      press(kind == 0 || kind == 2, kind == 1 || kind == 2, kind == 3, hold);
      chk("rnd_value", val0, m_val);
      chk("rnd_scan_sel", sel0, m_sel);
      chk("rnd_onehot", $countones(gnd0), 1);
      chk("rnd_seg", seg0, exp_seg(m_val, idx_of(gnd0), blank_en, 1'b1));
    end

    // ---- asynchronous reset mid-run while a button is held
    btn_inc = 1'b1;
    cyc(2);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_value", val0, 0);
    chk("midrst_grounds", gnd0, 4'b0001);
    chk("midrst_scan_sel", sel0, SSI);
    @(negedge clk);
    cyc(2);
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk($sformatf("rstpress_k%0d", k), val0, (k >= 7) ? 1 : 0);
    end
    btn_inc = 1'b0;
    cyc(12);
    m_val = 1; m_sel = SSI;
    chk("rstpress_once", val0, m_val);

    // ---- count up to 0x0070 and check each digit, blanking on then off
    while (m_val != 'h70) press(1, 0, 0, 5);
    chk("val_0070", val0, 16'h0070);
    for (int b = 1; b >= 0; b--) begin
      blank_en = 1'(b);
      for (int d = ND - 1; d >= 0; d--) begin
        wait_digit(1'b0, d);
        chk($sformatf("seg_b%0d_d%0d", b, d), seg0, exp_seg(m_val, d, blank_en, 1'b1));
      end
    end

    // ---- active-high polarity instance holding 0x0008
    for (int d = 0; d < ND; d++) begin
      wait_digit(1'b1, d);
      chk($sformatf("seg_hi_d%0d", d), seg1, exp_seg(8, d, 1'b1, 1'b0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
